// File: rtl/psg_reg_ctrl.sv
// SN76489-style register controller: latch/data byte decode, tone/att/noise
// registers, generator load pulses and READY busy timing in div16 ticks.
// Ports: clk, reset_n, clk_div16_en, we, din[7:0] in; ready, freq0-2[9:0],
//        att0-3[3:0], noise_ctrl[2:0], noise_reload, freq_load[2:0] out.
module psg_reg_ctrl #(
  parameter int          BUSY_TICKS  = 2,
  parameter logic [3:0]  RESET_ATTEN = 4'hF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_div16_en,
  input  logic       we,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] freq0,
  output logic [9:0] freq1,
  output logic [9:0] freq2,
  output logic [3:0] att0,
  output logic [3:0] att1,
  output logic [3:0] att2,
  output logic [3:0] att3,
  output logic [2:0] noise_ctrl,
  output logic       noise_reload,
  output logic [2:0] freq_load
);

  localparam int CW =
    (BUSY_TICKS < 1) ? 1 : $clog2(BUSY_TICKS + 1);

  logic [2:0][9:0] freq_q, freq_d;
  logic [3:0][3:0] att_q, att_d;
  logic [2:0]      noise_q, noise_d;
  logic [1:0]      lch_q, lch_d;
  logic            ltype_q, ltype_d;
  logic [2:0]      fl_q, fl_d;
  logic            nr_q, nr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            acc;
  logic [1:0]      ch;
  logic            typ;

  assign ready = (cnt_q == '0);
  assign acc   = we & ready;

  // A latch byte selects its own target; a data byte uses the stored latch.
  assign ch  = din[7] ? din[6:5] : lch_q;
  assign typ = din[7] ? din[4]   : ltype_q;

  always_comb begin
    freq_d  = freq_q;
    att_d   = att_q;
    noise_d = noise_q;
    lch_d   = lch_q;
    ltype_d = ltype_q;
    fl_d    = '0;
    nr_d    = 1'b0;
    cnt_d   = cnt_q;
    if (acc) begin
      cnt_d = CW'(BUSY_TICKS);
      if (din[7]) begin
        lch_d   = din[6:5];
        ltype_d = din[4];
      end
      unique case (1'b1)
        typ: att_d[ch] = din[3:0];
        (!typ && ch == 2'd3): begin
          noise_d = din[2:0];
          nr_d    = 1'b1;
        end
        default: begin
          for (int n = 0; n < 3; n++) begin
            if (ch == 2'(n)) begin
              if (din[7]) freq_d[n][3:0] = din[3:0];
              else        freq_d[n][9:4] = din[5:0];
              fl_d[n] = 1'b1;
            end
          end
        end
      endcase
    end else if (clk_div16_en && cnt_q != '0) begin
      // An enable on the accepting edge is skipped by the branch above.
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freq_q  <= '0;
      att_q   <= {4{RESET_ATTEN}};
      noise_q <= '0;
      lch_q   <= 2'd0;
      ltype_q <= 1'b0;
      fl_q    <= '0;
      nr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      freq_q  <= freq_d;
      att_q   <= att_d;
      noise_q <= noise_d;
      lch_q   <= lch_d;
      ltype_q <= ltype_d;
      fl_q    <= fl_d;
      nr_q    <= nr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign freq0        = freq_q[0];
  assign freq1        = freq_q[1];
  assign freq2        = freq_q[2];
  assign att0         = att_q[0];
  assign att1         = att_q[1];
  assign att2         = att_q[2];
  assign att3         = att_q[3];
  assign noise_ctrl   = noise_q;
  assign noise_reload = nr_q;
  assign freq_load    = fl_q;

endmodule

// File: tb/tb_psg_reg_ctrl.sv
// Testbench for psg_reg_ctrl: directed test-plan steps plus random
// writes checked against a behavioural register/busy model.
module tb_psg_reg_ctrl;

  localparam int BUSY = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_div16_en;
  logic       we;
  logic [7:0] din;
  logic       ready;
  logic [9:0] freq0, freq1, freq2;
  logic [3:0] att0, att1, att2, att3;
  logic [2:0] noise_ctrl;
  logic       noise_reload;
  logic [2:0] freq_load;

  psg_reg_ctrl #(.BUSY_TICKS(BUSY), .RESET_ATTEN(4'hF)) dut (
    .clk(clk), .reset_n(reset_n), .clk_div16_en(clk_div16_en),
    .we(we), .din(din), .ready(ready),
    .freq0(freq0), .freq1(freq1), .freq2(freq2),
    .att0(att0), .att1(att1), .att2(att2), .att3(att3),
    .noise_ctrl(noise_ctrl), .noise_reload(noise_reload),
    .freq_load(freq_load)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ph = 0;

  int m_freq[3];
  int m_att[4];
  int m_noise, m_lch, m_ltype, m_busy, m_fl, m_nr;

  task automatic cmp(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_freq[i] = 0;
    for (int i = 0; i < 4; i++) m_att[i] = 15;
    m_noise = 0; m_lch = 0; m_ltype = 0;
    m_busy = 0; m_fl = 0; m_nr = 0;
  endtask

  task automatic m_edge(input bit w, input int d, input bit e);
    int ch;
    int ty;
    bit acc;
    acc = w && (m_busy == 0);
    m_fl = 0;
    m_nr = 0;
    if (acc) begin
      if (d >= 128) begin
        m_lch   = (d / 32) % 4;
        m_ltype = (d / 16) % 2;
      end
      ch = m_lch;
      ty = m_ltype;
      if (ty == 1) m_att[ch] = d % 16;
      else if (ch == 3) begin
        m_noise = d % 8;
        m_nr = 1;
      end else begin
        if (d >= 128) m_freq[ch] = (m_freq[ch] / 16) * 16 + d % 16;
        else m_freq[ch] = m_freq[ch] % 16 + (d % 64) * 16;
        m_fl = 1 << ch;
      end
      m_busy = BUSY;
    end else if (e && m_busy > 0) begin
      m_busy--;
    end
  endtask

  task automatic check_all(input string t);
    cmp({t, ".ready"}, 16'(ready), 16'(m_busy == 0));
    cmp({t, ".freq0"}, 16'(freq0), 16'(m_freq[0]));
    cmp({t, ".freq1"}, 16'(freq1), 16'(m_freq[1]));
    cmp({t, ".freq2"}, 16'(freq2), 16'(m_freq[2]));
    cmp({t, ".att0"}, 16'(att0), 16'(m_att[0]));
    cmp({t, ".att1"}, 16'(att1), 16'(m_att[1]));
    cmp({t, ".att2"}, 16'(att2), 16'(m_att[2]));
    cmp({t, ".att3"}, 16'(att3), 16'(m_att[3]));
    cmp({t, ".noise"}, 16'(noise_ctrl), 16'(m_noise));
    cmp({t, ".nrld"}, 16'(noise_reload), 16'(m_nr));
    cmp({t, ".fload"}, 16'(freq_load), 16'(m_fl));
  endtask

  task automatic step(input bit w, input logic [7:0] d);
    bit e;
    e = (ph == 15);
    we = w;
    din = d;
    clk_div16_en = e;
    @(posedge clk);
    m_edge(w, int'(d), e);
    ph = (ph + 1) % 16;
    @(negedge clk);
    check_all("step");
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (m_busy != 0 && n < 200) begin
      step(1'b0, 8'h00);
      n++;
    end
    cmp("wait_ready_bound", 16'(n < 200), 16'd1);
  endtask

  task automatic wr(input logic [7:0] d);
    wait_ready();
    step(1'b1, d);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    we = 1'b0;
    din = 8'h00;
    clk_div16_en = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    repeat (3) step(1'b0, 8'h00);
    cmp("idle_ready", 16'(ready), 16'd1);
    cmp("idle_att3", 16'(att3), 16'hF);

    // Tone 0 low then high nibble; busy aligned to a coincident enable.
    wait_ready();
    while (ph != 15) step(1'b0, 8'h00);
    step(1'b1, 8'h8E);
    cmp("8E_fload", 16'(freq_load), 16'h1);
    n = 0;
    while (!ready && n < 100) begin
      step(1'b0, 8'h00);
      n++;
    end
    cmp("busy_cycles", 16'(n), 16'd32);
    wr(8'h0F);
    cmp("0F_fload", 16'(freq_load), 16'h1);
    step(1'b0, 8'h00);
    cmp("0F_fload_once", 16'(freq_load), 16'h0);
    cmp("freq0_0FE", 16'(freq0), 16'h0FE);

    // Attenuation latch then data.
    wr(8'hB5);
    cmp("att1_5", 16'(att1), 16'h5);
    wr(8'h03);
    cmp("att1_3", 16'(att1), 16'h3);
    cmp("att_freq0_keep", 16'(freq0), 16'h0FE);

    // Noise latch then data: two reload pulses.
    wr(8'hE6);
    cmp("noise_6", 16'(noise_ctrl), 16'h6);
    cmp("nrld_1", 16'(noise_reload), 16'h1);
    step(1'b0, 8'h00);
    cmp("nrld_1_end", 16'(noise_reload), 16'h0);
    wr(8'h01);
    cmp("noise_1", 16'(noise_ctrl), 16'h1);
    cmp("nrld_2", 16'(noise_reload), 16'h1);

    // Second write while busy is dropped.
    wr(8'hA3);
    step(1'b1, 8'h9C);
    cmp("freq1_lo3", 16'(freq1[3:0]), 16'h3);
    cmp("att0_keep", 16'(att0), 16'hF);
    cmp("ignored_busy", 16'(ready), 16'd0);

    // Reset in the middle of busy.
    wr(8'hC7);
    cmp("freq2_7", 16'(freq2), 16'h7);
    step(1'b0, 8'h00);
    clk_div16_en = 1'b0;
    we = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    cmp("rst_ready", 16'(ready), 16'd1);
    cmp("rst_freq2", 16'(freq2), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 8'h00);
    wr(8'h3F);
    cmp("freq0_3F0", 16'(freq0), 16'h3F0);

    // Random writes, randomly spaced, against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
